keypad_scanner: RTL and testbench

- Consumes the divided slow clock from the clock divider and uses it only as a scan-tick enable.
- Drives a 4x4 matrix keypad one column at a time and debounces presses and releases.
- Emits one registered key code and a single-cycle valid pulse per physical press.
- Feeds the downstream key-history/display logic; all logic runs on clk.

---
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_scanner.sv | 138 +++++++++++++
 tb/tb_keypad_scanner.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the accepted-key output towards the key-history logic.
// The scanner is the master: it drives columns and the key code, and senses rows.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;

    modport master (input rows, output cols, output key_code, output key_valid);
    modport slave  (output rows, input cols, input key_code, input key_valid);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks one active-low column per slow tick, debounces press and release.
// Latency: 2 clk sync + 1 clk edge detect, key_valid 1 clk after the confirming tick; no backpressure.
module keypad_scanner #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               slow_clk,
    keypad_scanner_if.master   kp
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DT = CW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    logic          slow_s1, slow_s2, slow_s3;
    logic [3:0]    rows_s1, rows_s2;
    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    cand_row_q, cand_row_d;
    logic [1:0]    cand_col_q, cand_col_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          tick, hit;
    logic [1:0]    win_row;

    always_ff @(posedge clk) begin
        if (!reset) begin
            slow_s1     <= 1'b0;
            slow_s2     <= 1'b0;
            slow_s3     <= 1'b0;
            rows_s1     <= 4'hF;
            rows_s2     <= 4'hF;
            state_q     <= SCAN;
            col_q       <= 2'd0;
            cnt_q       <= '0;
            cand_row_q  <= 2'd0;
            cand_col_q  <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            slow_s1     <= slow_clk;
            slow_s2     <= slow_s1;
            slow_s3     <= slow_s2;
            rows_s1     <= kp.rows;
            rows_s2     <= rows_s1;
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign tick    = slow_s2 & ~slow_s3;
    assign hit     = ~&rows_s2;
    assign cnt_inc = cnt_q + CW'(1);

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        win_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s2[i]) win_row = 2'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (!hit) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        cand_row_d = win_row;
                        cand_col_d = col_q;
                        cnt_d      = CW'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            key_code_d  = {win_row, col_q};
                            key_valid_d = 1'b1;
                            state_d     = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (hit && win_row == cand_row_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DT) begin
                            key_code_d  = {cand_row_q, cand_col_q};
                            key_valid_d = 1'b1;
                            state_d     = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!hit) begin
                        cnt_d = CW'(1);
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!hit) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DT) begin
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    assign kp.cols      = ~(4'b0001 << col_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised keypad bench: a key-matrix model drives rows from cols, a reference model predicts
// accepted keys into a queue, and a monitor pops and compares every key_valid pulse.
module tb_keypad_scanner;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        slow_clk = 1'b0;
    logic [15:0] pressed = 16'h0;

    keypad_scanner_if kp ();

    keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
        .clk      (clk),
        .reset    (reset),
        .slow_clk (slow_clk),
        .kp       (kp.master)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++)
            for (int ci = 0; ci < 4; ci++)
                if (pressed[4*ri+ci] && !kp.cols[ci]) r[ri] = 1'b0;
        kp.rows = r;
    end

    int n_checks = 0;
    int n_err    = 0;
    int n_expected = 0;
    int n_seen     = 0;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 scanning, 1 confirming a press, 2 key held, 3 confirming a release.
    int m_mode, m_col, m_cand, m_ccol, m_streak;

    function automatic int lowest_row(input logic [15:0] keys, input int col);
        for (int r = 0; r < 4; r++)
            if (keys[4*r+col]) return r;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_col = 0; m_cand = 0; m_ccol = 0; m_streak = 0;
        exp_q.delete();
    endtask

    task automatic model_tick();
        int r;
        r = lowest_row(pressed, m_col);
        case (m_mode)
            0: if (r < 0) m_col = (m_col + 1) % 4;
               else begin
                   m_cand = r; m_ccol = m_col; m_streak = 1; m_mode = 1;
               end
            1: if (r == m_cand) begin
                   m_streak++;
                   if (m_streak == DT) begin
                       exp_q.push_back(4*m_cand + m_ccol);
                       n_expected++;
                       m_mode = 2;
                   end
               end else m_mode = 0;
            2: if (r < 0) begin m_streak = 1; m_mode = 3; end
            default: if (r < 0) begin
                   m_streak++;
                   if (m_streak == DT) begin m_mode = 0; m_col = (m_col + 1) % 4; end
               end else m_mode = 2;
        endcase
    endtask

    // One slow-clock period with the given keys; afterwards the column and any pulse must have settled.
    task automatic do_tick(input logic [15:0] keys);
        pressed = keys;
        repeat ($urandom_range(4, 9)) @(negedge clk);
        slow_clk = 1'b1;
        model_tick();
        repeat (6) @(negedge clk);
        slow_clk = 1'b0;
        #1;
        check("cols", int'(kp.cols), 15 & ~(1 << m_col));
        check("pulse_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_cols", int'(kp.cols), 14);
        check("reset_key_code", int'(kp.key_code), 0);
        check("reset_key_valid", int'(kp.key_valid), 0);
        check("reset_no_pulse_owed", exp_q.size(), 0);
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (kp.key_valid) begin
            n_seen++;
            check("valid_back_to_back", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_code", int'(kp.key_code), -1);
            end else begin
                check("key_code", int'(kp.key_code), exp_q.pop_front());
            end
        end
        prev_valid = kp.key_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int sel;
        logic [15:0] keys;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Idle walk of the columns
        for (int i = 0; i < 4; i++) do_tick(16'h0);
        check("walk_back_to_col0", int'(kp.cols), 4'b1110);

        // Clean press of row 2 / col 1
        for (int i = 0; i < 4; i++) do_tick(16'h1 << 9);
        check("clean_code", int'(kp.key_code), 9);
        check("clean_cols_held", int'(kp.cols), 4'b1101);
        for (int i = 0; i < 3; i++) do_tick(16'h0);

        // Bounce at column 2: one low tick then high
        do_tick(16'h1 << 6);
        do_tick(16'h0);
        check("bounce_same_col", int'(kp.cols), 4'b1011);
        do_tick(16'h0);

        // Long hold of row 0 / col 3 with a release glitch
        for (int i = 0; i < 20; i++) do_tick(16'h1 << 3);
        check("hold_code", int'(kp.key_code), 3);
        do_tick(16'h0);
        do_tick(16'h1 << 3);
        for (int i = 0; i < 3; i++) do_tick(16'h0);
        check("release_cols", int'(kp.cols), 4'b1110);

        // Rows 1 and 3 in column 0
        for (int i = 0; i < 3; i++) do_tick((16'h1 << 4) | (16'h1 << 12));
        check("multirow_code", int'(kp.key_code), 4);
        for (int i = 0; i < 3; i++) do_tick(16'h0);

        // Reset during debounce of row 1 / col 1, key kept held across reset
        do_tick(16'h1 << 5);
        do_tick(16'h1 << 5);
        do_reset();
        for (int i = 0; i < 4; i++) do_tick(16'h1 << 5);
        check("after_reset_code", int'(kp.key_code), 5);
        for (int i = 0; i < 3; i++) do_tick(16'h0);

        // Randomised key activity
        keys = 16'h0;
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 4 && sel <= 6) keys = 16'h0;
            else if (sel >= 7 && sel <= 8) keys = 16'h1 << $urandom_range(0, 15);
            else if (sel == 9) keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            do_tick(keys);
        end
        for (int i = 0; i < 8; i++) do_tick(16'h0);

        check("pulse_count", n_seen, n_expected);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
